// File: rtl/knes_reg_pkg.sv
// Shared op encoding for the register bank and the future CPU datapath.
// decode_op applies the per-edge priority: latch > xfer > inc/dec.
package knes_reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_XFER = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } op_e;

  // inc and dec together cancel out, so the pair decodes to a hold.
  function automatic op_e decode_op(input logic latch, input logic xfer,
                                    input logic inc, input logic dec);
    if (latch)             return OP_LOAD;
    else if (xfer)         return OP_XFER;
    else if (inc && !dec)  return OP_INC;
    else if (dec && !inc)  return OP_DEC;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// reg_cell: one WIDTH-bit register executing a decoded op.
// wrap_o flags an inc from all-ones or a dec from zero in the current cycle.
module reg_cell
  import knes_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    q_d = q_q;
    unique case (op_i)
      OP_LOAD, OP_XFER: q_d = load_val_i;
      OP_INC:           q_d = q_q + 1'b1;
      OP_DEC:           q_d = q_q - 1'b1;
      default:          q_d = q_q;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so all cells see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q_o    = q_q;
  assign wrap_o = ((op_i == OP_INC) && (&q_q)) || ((op_i == OP_DEC) && (q_q == '0));

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH registers on a shared tri-state bus with load/inc/dec and flags.
// Optional register-to-register transfer is enabled by defining REG_BANK_XFER_EN.
module reg_bank
  import knes_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter int               SEL_W   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] data,
  input  logic [SEL_W-1:0] sel,
  input  logic             latch,
  input  logic             oe,
  input  logic             inc,
  input  logic             dec,
  output logic             zero,
  output logic             neg,
  output logic             wrap
`ifdef REG_BANK_XFER_EN
  ,
  input  logic             xfer,
  input  logic [SEL_W-1:0] src
`endif
);

  logic             xfer_en;
  logic [SEL_W-1:0] src_sel;

`ifdef REG_BANK_XFER_EN
  assign xfer_en = xfer;
  assign src_sel = src;
`else
  assign xfer_en = 1'b0;
  assign src_sel = '0;
`endif

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] cell_wrap;
  logic [WIDTH-1:0] rd_val, src_val, bus_val, load_val;
  op_e              op_sel;
  logic             wrap_q, wrap_d;

  // Out-of-range selects match no cell: reads return 0 and writes are dropped.
  always_comb begin
    rd_val  = '0;
    src_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i))     rd_val  = regs[i];
      if (src_sel == SEL_W'(i)) src_val = regs[i];
    end
  end

  // When we drive the bus ourselves the loaded value is our own output; taking it
  // directly avoids reading back through the tri-state resolution.
  assign bus_val  = oe ? rd_val : data;
  assign op_sel   = decode_op(latch, xfer_en, inc, dec);
  assign load_val = (op_sel == OP_XFER) ? src_val : bus_val;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    op_e cell_op;
    assign cell_op = (sel == SEL_W'(i)) ? op_sel : OP_HOLD;

    reg_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .op_i       (cell_op),
      .load_val_i (load_val),
      .q_o        (regs[i]),
      .wrap_o     (cell_wrap[i])
    );
  end

  assign wrap_d = |cell_wrap;

  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign data = oe ? rd_val : 'z;
  assign zero = (rd_val == '0);
  assign neg  = rd_val[WIDTH-1];
  assign wrap = wrap_q;

endmodule
